hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Parametrised successor to the EX-stage hazard unit for the 5-stage RV32I pipeline.
- Combinational operand forwarding, gated by RegWrite.
- Sequential load-use stall FSM with configurable load-to-use latency.
- Whole-pipeline freeze on data-memory not-ready; F/D/E flush on taken branch or jump redirect.
- Saturating stall/flush performance counters.

Parameters:
- REG_AW, 5, register address width.
- LOAD_LAT, 1, load-use stall cycles (1..15); >1 supports multi-cycle data memory/cache.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- Rs1D, Rs2D  in  REG_AW  source registers of the instruction in Decode.
- Rs1E, Rs2E  in  REG_AW  source registers of the instruction in Execute.
- RdE, RdM, RdW  in  REG_AW  destination registers in E/M/W.
- RegWriteM, RegWriteW  in  1  M/W instruction writes the register file.
- MemReadE  in  1  instruction in E is a load.
- BranchTakenE  in  1  resolved taken branch in E.
- JumpE  in  1  JAL/JALR in E.
- MemReady  in  1  data memory ready; low freezes the pipeline.
- CntClr  in  1  synchronous clear of the performance counters.
- ForwardAE, ForwardBE  out  2  00 = regfile, 01 = M result, 10 = W result.
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register.
- FlushD, FlushE  out  1  bubble the D / E pipeline register.
- StallCycles  out  CNT_W  number of cycles with StallD high.
- FlushEvents  out  CNT_W  number of cycles with FlushD high.

Behaviour:
- Forwarding (combinational, per operand, shown for A):
  - 01 if RegWriteM && RdM==Rs1E && Rs1E!=0.
  - Else 10 if RegWriteW && RdW==Rs1E && Rs1E!=0.
  - Else 00.
  - M takes priority over W. Register x0 is never forwarded. Operand B is identical using Rs2E.
- Load-use detect (combinational):
  - LU = MemReadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- FSM states: IDLE, LWAIT. Down-counter cnt has width 4.
- IDLE:
  - If LU && MemReady && no redirect: StallF = StallD = FlushE = 1.
  - If LOAD_LAT>1, go to LWAIT with cnt = LOAD_LAT-1.
- LWAIT:
  - StallF = StallD = FlushE = 1.
  - Each cycle with MemReady=1: cnt decrements; return to IDLE on the cycle cnt becomes 0.
  - Total stall length equals LOAD_LAT cycles.
- Redirect (BranchTakenE || JumpE) with MemReady=1:
  - FlushD = FlushE = 1; StallF = StallD = 0.
  - Overrides LU and LWAIT; FSM goes to IDLE.
- Memory freeze (MemReady=0):
  - StallF = StallD = StallE = StallM = 1; FlushD = FlushE = 0.
  - FSM and cnt hold.
  - A pending redirect or LU is serviced on the first cycle MemReady=1.
- Priority: rst > freeze > redirect > LWAIT > LU-in-IDLE.
- StallE and StallM are high only during freeze.
- Outputs are combinational from state and inputs. While rst=1, all stall and flush outputs are 0; forwarding stays functional.
- Counters:
  - Registered; +1 in each cycle the respective output is high.
  - Saturate at 2^CNT_W-1, no wrap.
  - CntClr zeroes both counters next edge and wins over increment in the same cycle.
- Reset: state IDLE, cnt 0, StallCycles 0, FlushEvents 0.
  - Reset asserted mid-LWAIT aborts the wait immediately.
  - No stall is asserted in the first cycle after release unless LU holds.

Test Plan:
- Forwarding: RdM = RdW = Rs1E = 5, RegWriteM = RegWriteW = 1 -> ForwardAE = 01. Drop RegWriteM -> 10. Rs1E = 0 -> 00.
- LOAD_LAT = 3, MemReadE = 1, RdE = 7, Rs2D = 7, MemReady = 1 -> StallD and FlushE high for exactly 3 cycles, then low; StallCycles = 3.
- LOAD_LAT = 3, MemReady low for 2 cycles during LWAIT -> freeze outputs all 1, FlushE = 0; load stall resumes and totals 5 StallD cycles.
- LU and BranchTakenE in the same cycle -> FlushD = FlushE = 1, StallD = 0, FSM IDLE; FlushEvents = 1.
- CNT_W = 2, hold MemReady = 0 for 6 cycles -> StallCycles saturates at 3. Assert CntClr with StallD high -> StallCycles = 0.
- Assert rst in the 2nd LWAIT cycle, release -> all outputs 0, counters 0, no residual stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage RV32I pipeline: operand forwarding, multi-cycle load-use stall,
// memory-not-ready freeze, redirect flush and saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemReadE,
    input  logic              BranchTakenE,
    input  logic              JumpE,
    input  logic              MemReady,
    input  logic              CntClr,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic [CNT_W-1:0]  StallCycles,
    output logic [CNT_W-1:0]  FlushEvents
);

    typedef enum logic {StIdle, StLwait} state_t;

    localparam logic [3:0]       LatM1  = 4'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       lu;
    logic       redir;

    // M result is younger than W, so it wins when both target the same register.
    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (RdM == Rs1E) && (Rs1E != '0)) begin
            ForwardAE = 2'b01;
        end else if (RegWriteW && (RdW == Rs1E) && (Rs1E != '0)) begin
            ForwardAE = 2'b10;
        end
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM == Rs2E) && (Rs2E != '0)) begin
            ForwardBE = 2'b01;
        end else if (RegWriteW && (RdW == Rs2E) && (Rs2E != '0)) begin
            ForwardBE = 2'b10;
        end
    end

    assign lu    = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign redir = BranchTakenE || JumpE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The first stall cycle is spent in StIdle, so the wait state covers LOAD_LAT-1 more cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (MemReady) begin
            if (redir) begin
                state_d = StIdle;
                cnt_d   = '0;
            end else if (state_q == StLwait) begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StIdle;
                end
            end else if (lu && (LOAD_LAT > 1)) begin
                state_d = StLwait;
                cnt_d   = LatM1;
            end
        end
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (!rst) begin
            if (!MemReady) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
            end else if (redir) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if ((state_q == StLwait) || lu) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCycles <= '0;
            FlushEvents <= '0;
        end else if (CntClr) begin
            StallCycles <= '0;
            FlushEvents <= '0;
        end else begin
            if (StallD && (StallCycles != CntMax)) begin
                StallCycles <= StallCycles + CntOne;
            end
            if (FlushD && (FlushEvents != CntMax)) begin
                FlushEvents <= FlushEvents + CntOne;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (LOAD_LAT 3/1/3, CNT_W 16/16/2) share one stimulus and
// are checked every cycle against an owed-stall-cycles model, plus directed scenario checks.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, MemReadE, BranchTakenE, JumpE, MemReady, CntClr;

    logic [1:0]  fa [3];
    logic [1:0]  fb [3];
    logic        sf [3];
    logic        sd [3];
    logic        se [3];
    logic        sm [3];
    logic        fd [3];
    logic        fle [3];
    logic [15:0] sc [3];
    logic [15:0] fe [3];
    logic [1:0]  sc2, fe2;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: owed load-stall cycles per instance and counter values.
    int lat [3] = '{3, 1, 3};
    int sat [3] = '{65535, 65535, 3};
    int rem [3] = '{0, 0, 0};
    int msc [3] = '{0, 0, 0};
    int mfe [3] = '{0, 0, 0};
    bit e_sd [3];
    bit e_fd [3];

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReadE(MemReadE), .BranchTakenE(BranchTakenE), .JumpE(JumpE), .MemReady(MemReady),
        .CntClr(CntClr), .ForwardAE(fa[0]), .ForwardBE(fb[0]), .StallF(sf[0]), .StallD(sd[0]),
        .StallE(se[0]), .StallM(sm[0]), .FlushD(fd[0]), .FlushE(fle[0]),
        .StallCycles(sc[0]), .FlushEvents(fe[0])
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReadE(MemReadE), .BranchTakenE(BranchTakenE), .JumpE(JumpE), .MemReady(MemReady),
        .CntClr(CntClr), .ForwardAE(fa[1]), .ForwardBE(fb[1]), .StallF(sf[1]), .StallD(sd[1]),
        .StallE(se[1]), .StallM(sm[1]), .FlushD(fd[1]), .FlushE(fle[1]),
        .StallCycles(sc[1]), .FlushEvents(fe[1])
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReadE(MemReadE), .BranchTakenE(BranchTakenE), .JumpE(JumpE), .MemReady(MemReady),
        .CntClr(CntClr), .ForwardAE(fa[2]), .ForwardBE(fb[2]), .StallF(sf[2]), .StallD(sd[2]),
        .StallE(se[2]), .StallM(sm[2]), .FlushD(fd[2]), .FlushE(fle[2]),
        .StallCycles(sc2), .FlushEvents(fe2)
    );

    assign sc[2] = {14'h0, sc2};
    assign fe[2] = {14'h0, fe2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (rs == 0) return 2'd0;
        if (RegWriteM && RdM == rs) return 2'd1;
        if (RegWriteW && RdW == rs) return 2'd2;
        return 2'd0;
    endfunction

    // Check all instances at the falling edge, then advance the model on the rising edge.
    task automatic step();
        bit lu, redir, frz, busy;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                rem[i] = 0; msc[i] = 0; mfe[i] = 0;
            end
        end
        @(negedge clk);
        lu    = MemReadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        redir = BranchTakenE || JumpE;
        frz   = !rst && !MemReady;
        for (int i = 0; i < 3; i++) begin
            busy    = !rst && MemReady && !redir && (rem[i] > 0 || lu);
            e_sd[i] = frz || busy;
            e_fd[i] = !rst && MemReady && redir;
            chk($sformatf("fwdA%0d", i), 32'(fa[i]), 32'(fwd(Rs1E)));
            chk($sformatf("fwdB%0d", i), 32'(fb[i]), 32'(fwd(Rs2E)));
            chk($sformatf("stallF%0d", i), 32'(sf[i]), 32'(e_sd[i]));
            chk($sformatf("stallD%0d", i), 32'(sd[i]), 32'(e_sd[i]));
            chk($sformatf("stallE%0d", i), 32'(se[i]), 32'(frz));
            chk($sformatf("stallM%0d", i), 32'(sm[i]), 32'(frz));
            chk($sformatf("flushD%0d", i), 32'(fd[i]), 32'(e_fd[i]));
            chk($sformatf("flushE%0d", i), 32'(fle[i]), 32'(e_fd[i] || busy));
            chk($sformatf("stallcnt%0d", i), 32'(sc[i]), 32'(msc[i]));
            chk($sformatf("flushcnt%0d", i), 32'(fe[i]), 32'(mfe[i]));
        end
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (MemReady) begin
                    if (redir) rem[i] = 0;
                    else if (rem[i] > 0) rem[i] = rem[i] - 1;
                    else if (lu) rem[i] = lat[i] - 1;
                end
                if (CntClr) begin
                    msc[i] = 0; mfe[i] = 0;
                end else begin
                    if (e_sd[i] && msc[i] < sat[i]) msc[i]++;
                    if (e_fd[i] && mfe[i] < sat[i]) mfe[i]++;
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteM, RegWriteW, MemReadE, BranchTakenE, JumpE, CntClr} = '0;
        MemReady = 1'b1;
    endtask

    task automatic clr_step();
        CntClr = 1'b1;
        step();
        CntClr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        step();

        // Forwarding priority and x0 exclusion
        RdM = 5; RdW = 5; Rs1E = 5; RegWriteM = 1; RegWriteW = 1;
        #1 chk("fwd_m", 32'(fa[0]), 32'd1);
        step();
        RegWriteM = 0;
        #1 chk("fwd_w", 32'(fa[0]), 32'd2);
        step();
        Rs1E = 0;
        #1 chk("fwd_x0", 32'(fa[0]), 32'd0);
        step();
        idle_inputs();

        // Three-cycle load-use stall
        MemReadE = 1; RdE = 7; Rs2D = 7;
        for (int k = 0; k < 3; k++) begin
            #1 chk("lu_stallD", 32'(sd[0]), 32'd1);
            chk("lu_flushE", 32'(fle[0]), 32'd1);
            step();
            MemReadE = 0;
        end
        #1 chk("lu_done", 32'(sd[0]), 32'd0);
        chk("lu_count", 32'(sc[0]), 32'd3);
        step();

        // Freeze in the middle of the wait
        clr_step();
        MemReadE = 1; RdE = 7; Rs2D = 7;
        step();
        MemReadE = 0; MemReady = 0;
        for (int k = 0; k < 2; k++) begin
            #1 chk("frz_stallE", 32'(se[0]), 32'd1);
            chk("frz_stallM", 32'(sm[0]), 32'd1);
            chk("frz_flushE", 32'(fle[0]), 32'd0);
            step();
        end
        MemReady = 1;
        step();
        step();
        #1 chk("frz_done", 32'(sd[0]), 32'd0);
        chk("frz_count", 32'(sc[0]), 32'd5);
        step();

        // Redirect beats load-use
        clr_step();
        MemReadE = 1; RdE = 7; Rs2D = 7; BranchTakenE = 1;
        #1 chk("br_flushD", 32'(fd[0]), 32'd1);
        chk("br_flushE", 32'(fle[0]), 32'd1);
        chk("br_stallD", 32'(sd[0]), 32'd0);
        step();
        idle_inputs();
        #1 chk("br_idle", 32'(sd[0]), 32'd0);
        chk("br_count", 32'(fe[0]), 32'd1);
        step();

        // Counter saturation and clear-wins
        clr_step();
        MemReady = 0;
        for (int k = 0; k < 6; k++) step();
        chk("sat_cnt2", 32'(sc[2]), 32'd3);
        chk("sat_cnt16", 32'(sc[0]), 32'd6);
        CntClr = 1;
        step();
        CntClr = 0;
        chk("clr_cnt2", 32'(sc[2]), 32'd0);
        MemReady = 1;
        step();

        // Reset in the second wait cycle
        MemReadE = 1; RdE = 7; Rs2D = 7;
        step();
        MemReadE = 0;
        step();
        rst = 1;
        #1 chk("rst_stallD", 32'(sd[0]), 32'd0);
        chk("rst_cnt", 32'(sc[0]), 32'd0);
        step();
        rst = 0;
        #1 chk("post_rst_stallD", 32'(sd[0]), 32'd0);
        chk("post_rst_flushE", 32'(fle[0]), 32'd0);
        chk("post_rst_cnt", 32'(sc[0]), 32'd0);
        step();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            RegWriteM    = 1'($urandom_range(0, 1));
            RegWriteW    = 1'($urandom_range(0, 1));
            MemReadE     = ($urandom_range(0, 2) == 0);
            BranchTakenE = ($urandom_range(0, 9) == 0);
            JumpE        = ($urandom_range(0, 15) == 0);
            MemReady     = ($urandom_range(0, 4) != 0);
            CntClr       = ($urandom_range(0, 31) == 0);
            rst          = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 0;
        idle_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
